// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer: sequences a 32-bit ADD or 16-bit SUB over an external
// 16-bit arithmetic unit (low half, then carry-chained high half, then flag).
// Optional feature macro: ALU_WIDE_SEQUENCER_ZFLAG_EN (zero-flag capture).
module alu_wide_sequencer (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iValid,
    output logic        oReady,
    input  logic        iOp,
    input  logic [31:0] iOperandA,
    input  logic [31:0] iOperandB,
    output logic [15:0] oPortA,
    output logic [15:0] oPortB,
    output logic [1:0]  oOpcode,
    input  logic [15:0] iAccumulator,
    input  logic        iCarryflag,
    input  logic        iZeroflag,
    output logic        oValid,
    input  logic        iReady,
    output logic [31:0] oResult,
    output logic        oCarry,
    output logic        oZero
);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        FLAG,
        DONE
    } state_t;

    localparam logic [1:0] OPC_NONE = 2'b00;
    localparam logic [1:0] OPC_ADD  = 2'b01;
    localparam logic [1:0] OPC_ADC  = 2'b10;
    localparam logic [1:0] OPC_SUB  = 2'b11;

    state_t      state;
    logic        op_sub;
    logic [15:0] a_hi;
    logic [15:0] b_hi;

    // Main sequencer: state plus all handshake, port and result registers
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state   <= IDLE;
            op_sub  <= 1'b0;
            a_hi    <= '0;
            b_hi    <= '0;
            oReady  <= 1'b1;
            oValid  <= 1'b0;
            oPortA  <= '0;
            oPortB  <= '0;
            oOpcode <= OPC_NONE;
            oResult <= '0;
            oCarry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // oReady is always high here, so iValid alone is the handshake;
                    // the low halves go straight to the ports, only high halves are kept
                    if (iValid) begin
                        op_sub  <= iOp;
                        a_hi    <= iOperandA[31:16];
                        b_hi    <= iOperandB[31:16];
                        oPortA  <= iOperandA[15:0];
                        oPortB  <= iOperandB[15:0];
                        oOpcode <= iOp ? OPC_SUB : OPC_ADD;
                        oReady  <= 1'b0;
                        state   <= LO;
                    end
                end
                LO: begin
                    oResult[15:0] <= iAccumulator;
                    if (op_sub) begin
                        oResult[31:16] <= '0;
                        oCarry         <= 1'b0;
                        oPortA         <= '0;
                        oPortB         <= '0;
                        oOpcode        <= OPC_NONE;
                        oValid         <= 1'b1;
                        state          <= DONE;
                    end else begin
                        oPortA  <= a_hi;
                        oPortB  <= b_hi;
                        oOpcode <= OPC_ADC;
                        state   <= HI;
                    end
                end
                HI: begin
                    oResult[31:16] <= iAccumulator;
                    oPortA         <= '0;
                    oPortB         <= '0;
                    oOpcode        <= OPC_NONE;
                    state          <= FLAG;
                end
                FLAG: begin
                    // carry from the high-half add is only visible one cycle later
                    oCarry <= iCarryflag;
                    oValid <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        oReady <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_WIDE_SEQUENCER_ZFLAG_EN
    logic zlo;

    // Zero flag: low-half zero captured in LO, combined with high-half zero in HI
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            zlo   <= 1'b0;
            oZero <= 1'b0;
        end else begin
            if (state == LO) begin
                zlo <= iZeroflag;
                if (op_sub) begin
                    oZero <= iZeroflag;
                end
            end
            if (state == HI) begin
                oZero <= zlo & iZeroflag;
            end
        end
    end
`else
    logic zflag_unused;
    assign zflag_unused = iZeroflag;
    assign oZero        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Testbench for alu_wide_sequencer: models the downstream 16-bit arithmetic
// unit and checks each transaction against plain 32/16-bit arithmetic.
module tb_alu_wide_sequencer;

`ifdef ALU_WIDE_SEQUENCER_ZFLAG_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic        iClock;
    logic        iReset;
    logic        iValid;
    logic        oReady;
    logic        iOp;
    logic [31:0] iOperandA;
    logic [31:0] iOperandB;
    logic [15:0] oPortA;
    logic [15:0] oPortB;
    logic [1:0]  oOpcode;
    logic [15:0] iAccumulator;
    logic        iCarryflag;
    logic        iZeroflag;
    logic        oValid;
    logic        iReady;
    logic [31:0] oResult;
    logic        oCarry;
    logic        oZero;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    alu_wide_sequencer dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iValid      (iValid),
        .oReady      (oReady),
        .iOp         (iOp),
        .iOperandA   (iOperandA),
        .iOperandB   (iOperandB),
        .oPortA      (oPortA),
        .oPortB      (oPortB),
        .oOpcode     (oOpcode),
        .iAccumulator(iAccumulator),
        .iCarryflag  (iCarryflag),
        .iZeroflag   (iZeroflag),
        .oValid      (oValid),
        .iReady      (iReady),
        .oResult     (oResult),
        .oCarry      (oCarry),
        .oZero       (oZero)
    );

    initial begin
        iClock = 1'b0;
        forever #5 iClock = ~iClock;
    end

    // Downstream arithmetic unit: combinational result, registered carry
    logic [16:0] au_sum;
    logic        au_carry;
    always_comb begin
        au_sum = '0;
        case (oOpcode)
            2'b01:   au_sum = {1'b0, oPortA} + {1'b0, oPortB};
            2'b10:   au_sum = {1'b0, oPortA} + {1'b0, oPortB} + {16'h0, au_carry};
            2'b11:   au_sum = {1'b0, oPortA} - {1'b0, oPortB};
            default: au_sum = '0;
        endcase
    end
    always @(posedge iClock or posedge iReset) begin
        if (iReset)              au_carry <= 1'b0;
        else if (oOpcode != 2'b00) au_carry <= au_sum[16];
    end
    assign iAccumulator = au_sum[15:0];
    assign iCarryflag   = au_carry;
    assign iZeroflag    = (au_sum[15:0] == 16'h0);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction; called with time at 1 unit after a rising edge.
    task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned hold, input bit keep, output int unsigned waits);
        logic [31:0] er;
        logic        ec;
        logic        ez;
        logic [31:0] ah;
        logic [31:0] bh;
        logic [31:0] al;
        logic [31:0] bl;
        int unsigned k;
        bit          acc;
        ah = {16'h0, a[31:16]};
        bh = {16'h0, b[31:16]};
        al = {16'h0, a[15:0]};
        bl = {16'h0, b[15:0]};
        if (op) begin
            er = {16'h0, a[15:0] - b[15:0]};
            ec = 1'b0;
        end else begin
            {ec, er} = {1'b0, a} + {1'b0, b};
        end
        ez = ZEN ? (er == 32'h0) : 1'b0;

        iOp = op; iOperandA = a; iOperandB = b; iValid = 1'b1;
        iReady = (hold == 0);
        waits = 0;
        acc = 1'b0;
        while (!acc && waits < 20) begin
            acc = oReady;
            @(posedge iClock); #1;
            waits++;
        end
        check_eq("accepted", {31'h0, acc}, 32'h1);
        if (!acc) begin
            iValid = 1'b0;
            return;
        end
        if (!keep) iValid = 1'b0;

        check_eq("lo_porta", {16'h0, oPortA}, al);
        check_eq("lo_portb", {16'h0, oPortB}, bl);
        check_eq("lo_opcode", {30'h0, oOpcode}, op ? 32'h3 : 32'h1);
        check_eq("busy_ready", {31'h0, oReady}, 32'h0);

        k = 0;
        do begin
            @(posedge iClock); #1;
            k++;
            if (k == 1) begin
                if (!op) begin
                    check_eq("hi_porta", {16'h0, oPortA}, ah);
                    check_eq("hi_portb", {16'h0, oPortB}, bh);
                    check_eq("hi_opcode", {30'h0, oOpcode}, 32'h2);
                end else begin
                    check_eq("done_opcode", {30'h0, oOpcode}, 32'h0);
                    check_eq("done_porta", {16'h0, oPortA}, 32'h0);
                end
            end
            if (!oValid) check_eq("busy_ready", {31'h0, oReady}, 32'h0);
        end while (!oValid && k < 10);

        check_eq("latency", k + 1, op ? 32'd2 : 32'd4);
        check_eq("result", oResult, er);
        check_eq("carry", {31'h0, oCarry}, {31'h0, ec});
        check_eq("zero", {31'h0, oZero}, {31'h0, ez});

        repeat (hold) begin
            @(posedge iClock); #1;
            check_eq("hold_valid", {31'h0, oValid}, 32'h1);
            check_eq("hold_result", oResult, er);
            check_eq("hold_ready", {31'h0, oReady}, 32'h0);
        end
        iReady = 1'b1;
        @(posedge iClock); #1;
        check_eq("post_valid", {31'h0, oValid}, 32'h0);
        check_eq("post_ready", {31'h0, oReady}, 32'h1);
        check_eq("post_result", oResult, er);
        check_eq("post_carry", {31'h0, oCarry}, {31'h0, ec});
        iValid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned w;
        int unsigned w2;
        bit          acc;
        int unsigned n;
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;

        iReset = 1'b1; iValid = 1'b0; iReady = 1'b0; iOp = 1'b0;
        iOperandA = '0; iOperandB = '0;
        @(posedge iClock); #1;
        check_eq("rst_valid", {31'h0, oValid}, 32'h0);
        check_eq("rst_result", oResult, 32'h0);
        check_eq("rst_ports", {oPortA, oPortB}, 32'h0);
        check_eq("rst_opcode", {30'h0, oOpcode}, 32'h0);
        check_eq("rst_flags", {30'h0, oCarry, oZero}, 32'h0);
        iReset = 1'b0;
        @(posedge iClock); #1;
        check_eq("rst_ready", {31'h0, oReady}, 32'h1);

        do_op(1'b0, 32'h0000FFFF, 32'h00000001, 0, 1'b0, w);
        do_op(1'b0, 32'hFFFFFFFF, 32'h00000001, 0, 1'b0, w);
        do_op(1'b1, 32'h12340005, 32'hABCD0003, 0, 1'b0, w);
        do_op(1'b0, 32'h12345678, 32'h9ABCDEF0, 5, 1'b1, w);
        do_op(1'b1, 32'h00000003, 32'h00000007, 5, 1'b1, w);
        do_op(1'b1, 32'hFFFF1234, 32'h00001234, 0, 1'b0, w);

        // back-to-back with iValid held and iReady high
        do_op(1'b0, 32'h80000000, 32'h80000000, 0, 1'b1, w);
        do_op(1'b0, 32'h0000FFFF, 32'h0000FFFF, 0, 1'b1, w2);
        check_eq("b2b_gap", w2, 32'd1);

        // reset in the middle of HI
        iOp = 1'b0; iOperandA = 32'h7FFFFFFF; iOperandB = 32'h00000001; iValid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 20) begin
            acc = oReady;
            @(posedge iClock); #1;
            n++;
        end
        check_eq("rst_accept", {31'h0, acc}, 32'h1);
        iValid = 1'b0;
        @(posedge iClock); #1;
        check_eq("rst_in_hi", {30'h0, oOpcode}, 32'h2);
        iReset = 1'b1;
        #1;
        check_eq("abort_valid", {31'h0, oValid}, 32'h0);
        check_eq("abort_result", oResult, 32'h0);
        check_eq("abort_ports", {oPortA, oPortB}, 32'h0);
        check_eq("abort_opcode", {30'h0, oOpcode}, 32'h0);
        check_eq("abort_flags", {30'h0, oCarry, oZero}, 32'h0);
        #1;
        iReset = 1'b0;
        #1;
        check_eq("abort_ready", {31'h0, oReady}, 32'h1);
        repeat (6) begin
            @(posedge iClock); #1;
            check_eq("abort_novalid", {31'h0, oValid}, 32'h0);
        end
        do_op(1'b0, 32'h00000002, 32'h00000003, 0, 1'b0, w);

        for (int i = 0; i < 24; i++) begin
            rop = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = rop ? rb : (32'h0 - rb);
            do_op(rop, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)), w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
